// File: rtl/mpu_pkg.sv
// rtl/mpu_pkg.sv - shared state type, MPU register map and length clamp for the I2C burst master
package mpu_pkg;

  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, ACK_AW, REG, ACK_REG, WDATA, ACK_WD,
    RSTART, ADDR_R, ACK_AR, RDATA, MACK, STOP, FIN
  } i2c_state_t;

  localparam logic [7:0] PWR_MGMT_1   = 8'h6B;
  localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;
  localparam logic [7:0] WHO_AM_I     = 8'h75;
  localparam logic [6:0] MPU_DEV_ADDR = 7'h68;

  // A zero-length request still reads one byte; oversize requests saturate.
  function automatic int clamp_len(input int len, input int max_len);
    if (len == 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/i2c_qtick.sv
// rtl/i2c_qtick.sv - quarter-bit divider: qtick strobe and 2-bit phase, held at zero while disabled
module i2c_qtick #(
  parameter int QDIV = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       qtick,
  output logic [1:0] phase
);

  localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;

  logic [CW-1:0] cnt;

  assign qtick = en && (cnt == CW'(QDIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 2'd0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 2'd0;
    end else if (qtick) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mpu_i2c_burst.sv
// rtl/mpu_i2c_burst.sv - I2C master for MPU-class IMUs: single-register write or N-byte burst read
module mpu_i2c_burst
  import mpu_pkg::*;
#(
  parameter int         CLK_FREQ = 50_000_000,
  parameter int         I2C_FREQ = 400_000,
  parameter logic [6:0] DEV_ADDR = MPU_DEV_ADDR,
  parameter int         MAX_LEN  = 14,
  localparam int        LW       = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          rd_mode,
  input  logic [7:0]    reg_addr,
  input  logic [7:0]    wr_data,
  input  logic [LW-1:0] rd_len,
  inout  wire           scl,
  inout  wire           sda,
  output logic          busy,
  output logic          done,
  output logic          ack_err,
  output logic [7:0]    rd_data,
  output logic          rd_valid
);

  localparam int QDIV_RAW = CLK_FREQ / (4 * I2C_FREQ);
  localparam int QDIV     = (QDIV_RAW < 2) ? 2 : QDIV_RAW;

  i2c_state_t    state, state_nx;
  logic          qtick, sample, slot_end, run, data_scl;
  logic [1:0]    phase;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sr;
  logic [6:0]    rx_sr;
  logic [LW-1:0] byte_cnt;
  logic          rd_mode_q, err;
  logic [7:0]    reg_q, wdata_q;
  logic          scl_low, sda_low, scl_low_q, sda_low_q;
  logic          sda_meta, sda_in;

  i2c_qtick #(.QDIV(QDIV)) u_qtick (
    .clk   (clk),
    .rst   (rst),
    .en    (run),
    .qtick (qtick),
    .phase (phase)
  );

  assign run      = (state != IDLE) && (state != FIN);
  assign busy     = run;
  assign done     = (state == FIN);
  assign ack_err  = done && err;
  assign sample   = qtick && (phase == 2'd2);
  assign slot_end = qtick && (phase == 2'd3);
  assign data_scl = (phase == 2'd0) || (phase == 2'd3);

  assign scl = scl_low_q ? 1'b0 : 1'bz;
  assign sda = sda_low_q ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    scl_low  = 1'b0;
    sda_low  = 1'b0;
    case (state)
      IDLE: if (start) state_nx = START;
      START: begin
        scl_low = (phase == 2'd3);
        sda_low = phase[1];
        if (slot_end) state_nx = ADDR_W;
      end
      // Repeated start: release sda under a low scl, then a normal START edge.
      RSTART: begin
        scl_low = data_scl;
        sda_low = phase[1];
        if (slot_end) state_nx = ADDR_R;
      end
      ADDR_W, REG, WDATA, ADDR_R: begin
        scl_low = data_scl;
        sda_low = !tx_sr[7];
        if (slot_end && bit_cnt == 3'd0) begin
          case (state)
            ADDR_W:  state_nx = ACK_AW;
            REG:     state_nx = ACK_REG;
            WDATA:   state_nx = ACK_WD;
            default: state_nx = ACK_AR;
          endcase
        end
      end
      ACK_AW: begin
        scl_low = data_scl;
        if (slot_end) state_nx = err ? STOP : REG;
      end
      ACK_REG: begin
        scl_low = data_scl;
        if (slot_end) state_nx = err ? STOP : (rd_mode_q ? RSTART : WDATA);
      end
      ACK_WD: begin
        scl_low = data_scl;
        if (slot_end) state_nx = STOP;
      end
      ACK_AR: begin
        scl_low = data_scl;
        if (slot_end) state_nx = err ? STOP : RDATA;
      end
      RDATA: begin
        scl_low = data_scl;
        if (slot_end && bit_cnt == 3'd0) state_nx = MACK;
      end
      MACK: begin
        scl_low = data_scl;
        sda_low = (byte_cnt != LW'(1));
        if (slot_end) state_nx = (byte_cnt == LW'(1)) ? STOP : RDATA;
      end
      STOP: begin
        scl_low = (phase == 2'd0);
        sda_low = !phase[1];
        if (slot_end) state_nx = FIN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_mode_q <= 1'b0;
      reg_q     <= '0;
      wdata_q   <= '0;
      byte_cnt  <= '0;
      err       <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= 3'd7;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (state == IDLE && start) begin
        rd_mode_q <= rd_mode;
        reg_q     <= reg_addr;
        wdata_q   <= wr_data;
        byte_cnt  <= LW'(clamp_len(int'(rd_len), MAX_LEN));
        err       <= 1'b0;
        tx_sr     <= {DEV_ADDR, 1'b0};
        bit_cnt   <= 3'd7;
      end
      if (sample) begin
        case (state)
          ACK_AW, ACK_REG, ACK_WD, ACK_AR: if (sda_in) err <= 1'b1;
          RDATA: begin
            rx_sr <= {rx_sr[5:0], sda_in};
            if (bit_cnt == 3'd0) begin
              rd_data  <= {rx_sr, sda_in};
              rd_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      // bit_cnt wraps 0 -> 7 at the end of every byte, ready for the next one.
      if (slot_end) begin
        case (state)
          ADDR_W, REG, WDATA, ADDR_R, RDATA: begin
            tx_sr   <= {tx_sr[6:0], 1'b0};
            bit_cnt <= bit_cnt - 3'd1;
          end
          ACK_AW:  tx_sr <= reg_q;
          ACK_REG: tx_sr <= rd_mode_q ? {DEV_ADDR, 1'b1} : wdata_q;
          MACK:    if (byte_cnt != LW'(1)) byte_cnt <= byte_cnt - LW'(1);
          default: ;
        endcase
      end
    end
  end

  // Pin drives are registered; sda is resynchronised before sampling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_low_q <= 1'b0;
      sda_low_q <= 1'b0;
      sda_meta  <= 1'b1;
      sda_in    <= 1'b1;
    end else begin
      scl_low_q <= scl_low;
      sda_low_q <= sda_low;
      sda_meta  <= sda;
      sda_in    <= sda_meta;
    end
  end

endmodule

// File: tb/tb_mpu_i2c_burst.sv
// tb/tb_mpu_i2c_burst.sv - directed self-checking bench with an I2C slave model for mpu_i2c_burst
module tb_mpu_i2c_burst;
  import mpu_pkg::*;

  localparam int LW      = 4;
  localparam int EV_S    = 1000;
  localparam int EV_P    = 1001;
  localparam int EV_ACK  = 2000;
  localparam int EV_NACK = 2001;
  localparam int EV_RD   = 3000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, rd_mode = 1'b0;
  logic [7:0]    reg_addr = '0, wr_data = '0;
  logic [LW-1:0] rd_len = '0;
  wire           scl, sda;
  logic          busy, done, ack_err, rd_valid;
  logic [7:0]    rd_data;

  pullup (scl);
  pullup (sda);

  logic slv_sda_low = 1'b0;
  assign sda = slv_sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  mpu_i2c_burst dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rd_mode  (rd_mode),
    .reg_addr (reg_addr),
    .wr_data  (wr_data),
    .rd_len   (rd_len),
    .scl      (scl),
    .sda      (sda),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, valid_cnt = 0;
  logic err_last = 1'b0, busy_at_done = 1'b0;
  logic [7:0] rdq[$];
  int evq[$], exp_q[$], rise_t[$];
  logic [7:0] rd_src[16];
  bit slv_present = 1'b1, slv_abort = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor
  initial forever begin
    @(negedge clk);
    cyc++;
    if (done === 1'b1) begin
      done_cnt++;
      err_last     = ack_err;
      busy_at_done = busy;
    end
    if (rd_valid === 1'b1) begin
      valid_cnt++;
      rdq.push_back(rd_data);
    end
  end

  // Slave: logs START/STOP, master-written bytes, ack bits and slave-sent bytes
  initial begin : slave
    logic ps, pd, cs, cd;
    logic [7:0] sh, tx;
    int bitn, idx;
    bit first, rdm, matched, stop_tx;
    ps = 1'b1; pd = 1'b1; sh = '0; tx = '0;
    bitn = 0; idx = 0; first = 0; rdm = 0; matched = 0; stop_tx = 0;
    forever begin
      @(posedge clk);
      cs = scl;
      cd = sda;
      if (slv_abort) begin
        slv_sda_low = 1'b0; bitn = 0; rdm = 0; matched = 0;
      end else if (ps && cs && pd && !cd) begin
        evq.push_back(EV_S);
        bitn = 0; first = 1; rdm = 0; matched = 0; stop_tx = 0; idx = 0;
      end else if (ps && cs && !pd && cd) begin
        evq.push_back(EV_P);
        slv_sda_low = 1'b0; bitn = 0; rdm = 0; matched = 0;
      end else if (!ps && cs) begin
        rise_t.push_back(cyc);
        if (bitn < 8) begin
          sh = {sh[6:0], cd};
          bitn++;
        end else begin
          evq.push_back(EV_ACK + int'(cd));
          if (rdm && cd) stop_tx = 1;
          bitn = 0;
        end
      end else if (ps && !cs) begin
        if (bitn == 8) begin
          if (rdm) begin
            evq.push_back(EV_RD + int'(sh));
            slv_sda_low = 1'b0;
          end else begin
            evq.push_back(int'(sh));
            if (first) begin
              matched = slv_present && (sh[7:1] == 7'h68);
              rdm     = sh[0] && matched;
              first   = 0;
            end
            slv_sda_low = matched;
          end
        end else if (rdm && !stop_tx) begin
          if (bitn == 0) begin
            tx = rd_src[idx];
            idx++;
          end
          slv_sda_low = !tx[7-bitn];
        end else begin
          slv_sda_low = 1'b0;
        end
      end
      ps = cs;
      pd = cd;
    end
  end

  task automatic go(input bit rm, input logic [7:0] ra, input logic [7:0] wd, input logic [LW-1:0] len);
    @(negedge clk);
    start = 1'b1; rd_mode = rm; reg_addr = ra; wr_data = wd; rd_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int t0 = done_cnt;
    int n = 0;
    while (done_cnt == t0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'b0, n < budget}, 32'd1);
  endtask

  task automatic clear_logs();
    evq.delete(); rdq.delete(); rise_t.delete();
    valid_cnt = 0;
  endtask

  task automatic exp_write(input logic [7:0] r, input logic [7:0] d);
    exp_q.delete();
    exp_q.push_back(EV_S);   exp_q.push_back(32'hD0); exp_q.push_back(EV_ACK);
    exp_q.push_back(int'(r)); exp_q.push_back(EV_ACK);
    exp_q.push_back(int'(d)); exp_q.push_back(EV_ACK);
    exp_q.push_back(EV_P);
  endtask

  task automatic exp_read(input logic [7:0] r, input int n);
    exp_q.delete();
    exp_q.push_back(EV_S);   exp_q.push_back(32'hD0); exp_q.push_back(EV_ACK);
    exp_q.push_back(int'(r)); exp_q.push_back(EV_ACK);
    exp_q.push_back(EV_S);   exp_q.push_back(32'hD1); exp_q.push_back(EV_ACK);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(EV_RD + int'(rd_src[i]));
      exp_q.push_back((i == n - 1) ? EV_NACK : EV_ACK);
    end
    exp_q.push_back(EV_P);
  endtask

  task automatic check_ev(input string tag);
    check({tag, "_len"}, evq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < evq.size(); i++)
      check($sformatf("%s[%0d]", tag, i), evq[i], exp_q[i]);
  endtask

  initial begin
    int d0, n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_scl", {31'b0, scl}, 32'd1);
    check("rst_sda", {31'b0, sda}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_ack_err", {31'b0, ack_err}, 32'd0);
    check("rst_rd_data", {24'b0, rd_data}, 32'h00);
    check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single write PWR_MGMT_1 <= 0x00
    clear_logs();
    d0 = done_cnt;
    go(0, PWR_MGMT_1, 8'h00, '0);
    check("wr_busy", {31'b0, busy}, 32'd1);
    wait_done(6000, "wr_timeout");
    @(negedge clk);
    check("wr_done_cnt", done_cnt - d0, 32'd1);
    check("wr_ack_err", {31'b0, err_last}, 32'd0);
    check("wr_busy_at_done", {31'b0, busy_at_done}, 32'd0);
    check("wr_rd_valid", valid_cnt, 32'd0);
    exp_write(8'h6B, 8'h00);
    check_ev("wr_bus");
    for (int i = 0; i < 8 && i + 1 < rise_t.size(); i++) begin
      n = rise_t[i+1] - rise_t[i];
      check($sformatf("scl_period[%0d]", i), {31'b0, (n >= 123 && n <= 125)}, 32'd1);
    end

    // Burst read of 14 bytes from ACCEL_XOUT_H
    for (int i = 0; i < 16; i++) rd_src[i] = 8'(i + 1);
    clear_logs();
    go(1, ACCEL_XOUT_H, 8'h00, 4'd14);
    wait_done(25000, "rd14_timeout");
    @(negedge clk);
    check("rd14_ack_err", {31'b0, err_last}, 32'd0);
    check("rd14_valid_cnt", valid_cnt, 32'd14);
    for (int i = 0; i < 14 && i < rdq.size(); i++)
      check($sformatf("rd14_data[%0d]", i), {24'b0, rdq[i]}, 32'(i + 1));
    exp_read(8'h3B, 14);
    check_ev("rd14_bus");

    // Slave absent: address NACK
    slv_present = 1'b0;
    clear_logs();
    go(1, ACCEL_XOUT_H, 8'h00, 4'd14);
    wait_done(4000, "nack_timeout");
    @(negedge clk);
    check("nack_ack_err", {31'b0, err_last}, 32'd1);
    check("nack_valid_cnt", valid_cnt, 32'd0);
    exp_q.delete();
    exp_q.push_back(EV_S); exp_q.push_back(32'hD0); exp_q.push_back(EV_NACK); exp_q.push_back(EV_P);
    check_ev("nack_bus");
    slv_present = 1'b1;

    // start while busy is dropped
    clear_logs();
    d0 = done_cnt;
    go(0, PWR_MGMT_1, 8'h01, '0);
    repeat (50) @(negedge clk);
    go(1, ACCEL_XOUT_H, 8'h00, 4'd3);
    wait_done(6000, "drop_timeout");
    repeat (40) @(negedge clk);
    check("drop_done_cnt", done_cnt - d0, 32'd1);
    check("drop_busy_after", {31'b0, busy}, 32'd0);
    check("drop_valid_cnt", valid_cnt, 32'd0);
    exp_write(8'h6B, 8'h01);
    check_ev("drop_bus");

    // rd_len = 0 reads exactly one byte
    rd_src[0] = 8'hA5;
    clear_logs();
    go(1, ACCEL_XOUT_H, 8'h00, 4'd0);
    wait_done(8000, "len0_timeout");
    @(negedge clk);
    check("len0_valid_cnt", valid_cnt, 32'd1);
    if (rdq.size() > 0) check("len0_data", {24'b0, rdq[0]}, 32'hA5);
    exp_read(8'h3B, 1);
    check_ev("len0_bus");

    // Reset during the 5th byte of a 14-byte read
    for (int i = 0; i < 16; i++) rd_src[i] = 8'(i + 1);
    clear_logs();
    go(1, ACCEL_XOUT_H, 8'h00, 4'd14);
    n = 0;
    while (valid_cnt < 4 && n < 12000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_byte5", {31'b0, n < 12000}, 32'd1);
    repeat (300) @(negedge clk);
    d0 = done_cnt;
    rst = 1'b1;
    slv_abort = 1'b1;
    @(posedge clk);
    #1;
    check("abort_scl", {31'b0, scl}, 32'd1);
    check("abort_sda", {31'b0, sda}, 32'd1);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_rd_data", {24'b0, rd_data}, 32'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    slv_abort = 1'b0;
    repeat (200) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 32'd0);
    check("abort_valid_cnt", valid_cnt, 32'd4);
    check("abort_idle_busy", {31'b0, busy}, 32'd0);

    // WHO_AM_I after the abort
    rd_src[0] = 8'h68;
    clear_logs();
    go(1, WHO_AM_I, 8'h00, 4'd1);
    wait_done(8000, "who_timeout");
    @(negedge clk);
    check("who_ack_err", {31'b0, err_last}, 32'd0);
    check("who_valid_cnt", valid_cnt, 32'd1);
    if (rdq.size() > 0) check("who_data", {24'b0, rdq[0]}, 32'h68);
    exp_read(8'h75, 1);
    check_ev("who_bus");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
